// File: rtl/game_round_ctrl.sv
// rtl/game_round_ctrl.sv - round sequencer driving the countdown timer's Start and game_over inputs
//
// Purpose: steps through NUM_ROUNDS rounds, tracks round number and lives,
//          and declares win or lose. The timer's time_up feeds back here.
// Optional feature: define LIFE_BONUS_EN so that a cleared round which leads
//          into RESTART also restores one life, saturating at NUM_LIVES.
// Ports:
//   CLK, RESET_N            clock; asynchronous active-low reset
//   btn_start, btn_pause    debounced buttons (levels; rising edges are used)
//   goal_hit, player_dead   game logic round results (levels)
//   time_up                 timer has reached REACH
//   timer_start             one-cycle pulse to the timer Start input
//   timer_stop              level to the timer game_over input
//   in_play                 high while in RUN
//   round_num [3:0]         current round, 1-based
//   lives [1:0]             remaining lives
//   ctrl_state [2:0]        IDLE=0 RUN=1 PAUSED=2 ROUND_END=3 RESTART=4 WIN=5 LOSE=6
//   win, lose               high while in WIN / LOSE
module game_round_ctrl #(
  parameter int NUM_ROUNDS = 5,
  parameter int NUM_LIVES  = 3,
  parameter int END_HOLD   = 100_000_000
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       goal_hit,
  input  logic       player_dead,
  input  logic       time_up,
  output logic       timer_start,
  output logic       timer_stop,
  output logic       in_play,
  output logic [3:0] round_num,
  output logic [1:0] lives,
  output logic [2:0] ctrl_state,
  output logic       win,
  output logic       lose
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    PAUSED    = 3'd2,
    ROUND_END = 3'd3,
    RESTART   = 3'd4,
    WIN       = 3'd5,
    LOSE      = 3'd6
  } state_t;

  // The hold counter must reach END_HOLD itself: ROUND_END lasts END_HOLD+1 cycles
  // (counter values 0..END_HOLD-1, then one evaluation cycle).
  localparam int HW = $clog2(END_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(END_HOLD);
  localparam logic [3:0]    ROUND_LAST = 4'(NUM_ROUNDS);
  localparam logic [1:0]    LIVES_INIT = 2'(NUM_LIVES);

  state_t          state_q, state_d;
  logic [3:0]      round_d;
  logic [1:0]      lives_d;
  logic            clear_q, clear_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [1:0]      rcnt_q, rcnt_d;
  logic            tstart_d;
  logic            start_q, pause_q;
  logic            start_rise, pause_rise;

  // Edge registers reset to 0, so a button held through reset release gives one rise.
  assign start_rise = btn_start & ~start_q;
  assign pause_rise = btn_pause & ~pause_q;

  assign ctrl_state = state_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      round_num   <= 4'd1;
      lives       <= LIVES_INIT;
      clear_q     <= 1'b0;
      hold_q      <= '0;
      rcnt_q      <= 2'd0;
      start_q     <= 1'b0;
      pause_q     <= 1'b0;
      timer_start <= 1'b0;
      timer_stop  <= 1'b0;
      in_play     <= 1'b0;
      win         <= 1'b0;
      lose        <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_num   <= round_d;
      lives       <= lives_d;
      clear_q     <= clear_d;
      hold_q      <= hold_d;
      rcnt_q      <= rcnt_d;
      start_q     <= btn_start;
      pause_q     <= btn_pause;
      timer_start <= tstart_d;
      // Level outputs are registered from the next state so they line up with ctrl_state.
      timer_stop  <= (state_d == ROUND_END);
      in_play     <= (state_d == RUN);
      win         <= (state_d == WIN);
      lose        <= (state_d == LOSE);
    end
  end

  always_comb begin
    state_d  = state_q;
    round_d  = round_num;
    lives_d  = lives;
    clear_d  = clear_q;
    hold_d   = hold_q;
    rcnt_d   = rcnt_q;
    tstart_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_rise) begin
          state_d  = RUN;
          tstart_d = 1'b1;
          round_d  = 4'd1;
          lives_d  = LIVES_INIT;
        end
      end

      RUN: begin
        if (pause_rise) begin
          state_d = PAUSED;
        end else if (goal_hit) begin
          // goal_hit wins over a same-cycle time_up / player_dead.
          state_d = ROUND_END;
          clear_d = 1'b1;
          hold_d  = '0;
        end else if (player_dead || time_up) begin
          state_d = ROUND_END;
          clear_d = 1'b0;
          hold_d  = '0;
        end
      end

      PAUSED: begin
        if (start_rise || pause_rise) begin
          state_d  = RUN;
          tstart_d = 1'b1;
        end
      end

      ROUND_END: begin
        if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          if (clear_q) begin
            if (round_num >= ROUND_LAST) begin
              state_d = WIN;
            end else begin
              state_d  = RESTART;
              rcnt_d   = 2'd0;
              tstart_d = 1'b1;
              round_d  = round_num + 4'd1;
`ifdef LIFE_BONUS_EN
              if (lives < LIVES_INIT) begin
                lives_d = lives + 2'd1;
              end
`endif
            end
          end else begin
            if (lives <= 2'd1) begin
              state_d = LOSE;
              lives_d = 2'd0;
            end else begin
              state_d  = RESTART;
              rcnt_d   = 2'd0;
              tstart_d = 1'b1;
              lives_d  = lives - 2'd1;
            end
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      RESTART: begin
        // r=0 pulse is issued on entry; the second pulse lands on r=3.
        if (rcnt_q == 2'd3) begin
          state_d = RUN;
          rcnt_d  = 2'd0;
        end else begin
          rcnt_d = rcnt_q + 2'd1;
          if (rcnt_q == 2'd2) begin
            tstart_d = 1'b1;
          end
        end
      end

      WIN, LOSE: begin
        if (start_rise) begin
          state_d  = IDLE;
          tstart_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_game_round_ctrl.sv
// tb/tb_game_round_ctrl.sv - directed self-checking bench for game_round_ctrl
module tb_game_round_ctrl;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_pause = 1'b0;
  logic       goal_hit = 1'b0;
  logic       player_dead = 1'b0;
  logic       time_up = 1'b0;
  logic       timer_start, timer_stop, in_play, win, lose;
  logic [3:0] round_num;
  logic [1:0] lives;
  logic [2:0] ctrl_state;

  int checks = 0;
  int failures = 0;

  game_round_ctrl #(
    .NUM_ROUNDS(2),
    .NUM_LIVES (2),
    .END_HOLD  (4)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .btn_start  (btn_start),
    .btn_pause  (btn_pause),
    .goal_hit   (goal_hit),
    .player_dead(player_dead),
    .time_up    (time_up),
    .timer_start(timer_start),
    .timer_stop (timer_stop),
    .in_play    (in_play),
    .round_num  (round_num),
    .lives      (lives),
    .ctrl_state (ctrl_state),
    .win        (win),
    .lose       (lose)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  // Press start for one cycle; checks the state reached and the single timer_start pulse.
  task automatic press_start(input string tag, input logic [2:0] exp_state);
    btn_start = 1'b1;
    cyc();
    check_val({tag, "_state"}, 32'(ctrl_state), 32'(exp_state));
    check_val({tag, "_tstart"}, 32'(timer_start), 32'd1);
    btn_start = 1'b0;
    cyc();
    check_val({tag, "_tstart_off"}, 32'(timer_start), 32'd0);
  endtask

  // Count the cycles spent with timer_stop high (bounded), leaving us on the first cycle after ROUND_END.
  task automatic wait_hold(input string tag);
    int n;
    n = 0;
    while (timer_stop && n < 20) begin
      n++;
      cyc();
    end
    check_val({tag, "_hold_cycles"}, 32'(n), 32'd5);
  endtask

  // Walk RESTART r=0..3 and into RUN.
  task automatic check_restart(input string tag, input logic [3:0] exp_round, input logic [1:0] exp_lives);
    check_val({tag, "_rs_state"}, 32'(ctrl_state), 32'd4);
    check_val({tag, "_rs_ts0"}, 32'(timer_start), 32'd1);
    check_val({tag, "_rs_round"}, 32'(round_num), 32'(exp_round));
    check_val({tag, "_rs_lives"}, 32'(lives), 32'(exp_lives));
    cyc();
    check_val({tag, "_rs_ts1"}, 32'(timer_start), 32'd0);
    cyc();
    check_val({tag, "_rs_ts2"}, 32'(timer_start), 32'd0);
    cyc();
    check_val({tag, "_rs_ts3"}, 32'(timer_start), 32'd1);
    check_val({tag, "_rs_stop"}, 32'(timer_stop), 32'd0);
    cyc();
    check_val({tag, "_run_state"}, 32'(ctrl_state), 32'd1);
    check_val({tag, "_run_ts"}, 32'(timer_start), 32'd0);
    check_val({tag, "_run_inplay"}, 32'(in_play), 32'd1);
  endtask

  initial begin
    cyc(2);
    check_val("rst_state", 32'(ctrl_state), 32'd0);
    check_val("rst_round", 32'(round_num), 32'd1);
    check_val("rst_lives", 32'(lives), 32'd2);
    check_val("rst_outs", 32'({timer_start, timer_stop, in_play, win, lose}), 32'd0);
    RESET_N = 1'b1;
    cyc();

    // Game 1: clear both rounds.
    press_start("start1", 3'd1);
    check_val("start1_round", 32'(round_num), 32'd1);
    check_val("start1_lives", 32'(lives), 32'd2);
    btn_start = 1'b1;
    cyc();
    check_val("run_start_ignored", 32'(ctrl_state), 32'd1);
    btn_start = 1'b0;
    goal_hit = 1'b1;
    cyc();
    goal_hit = 1'b0;
    check_val("re1_state", 32'(ctrl_state), 32'd3);
    check_val("re1_stop", 32'(timer_stop), 32'd1);
    wait_hold("re1");
    check_restart("r2", 4'd2, 2'd2);
    goal_hit = 1'b1;
    cyc();
    goal_hit = 1'b0;
    wait_hold("re2");
    check_val("win_state", 32'(ctrl_state), 32'd5);
    check_val("win_flag", 32'(win), 32'd1);
    check_val("win_ts", 32'(timer_start), 32'd0);
    cyc(2);
    check_val("win_hold", 32'(win), 32'd1);
    press_start("win_to_idle", 3'd0);

    // Game 2: time out twice and lose.
    press_start("start2", 3'd1);
    time_up = 1'b1;
    cyc();
    time_up = 1'b0;
    wait_hold("fail1");
    check_restart("f1", 4'd1, 2'd1);
    player_dead = 1'b1;
    cyc();
    player_dead = 1'b0;
    wait_hold("fail2");
    check_val("lose_state", 32'(ctrl_state), 32'd6);
    check_val("lose_flag", 32'(lose), 32'd1);
    check_val("lose_lives", 32'(lives), 32'd0);
    check_val("lose_round", 32'(round_num), 32'd1);
    press_start("lose_to_idle", 3'd0);

    // Game 3: pause, ignored goal, resume, simultaneous goal + time_up.
    press_start("start3", 3'd1);
    check_val("start3_lives", 32'(lives), 32'd2);
    btn_pause = 1'b1;
    cyc();
    check_val("pause_state", 32'(ctrl_state), 32'd2);
    check_val("pause_ts", 32'(timer_start), 32'd0);
    check_val("pause_inplay", 32'(in_play), 32'd0);
    btn_pause = 1'b0;
    goal_hit = 1'b1;
    time_up = 1'b1;
    cyc();
    check_val("pause_goal_ignored", 32'(ctrl_state), 32'd2);
    goal_hit = 1'b0;
    time_up = 1'b0;
    press_start("resume", 3'd1);
    goal_hit = 1'b1;
    time_up = 1'b1;
    cyc();
    goal_hit = 1'b0;
    time_up = 1'b0;
    wait_hold("both");
    check_val("both_state", 32'(ctrl_state), 32'd4);
    check_val("both_round", 32'(round_num), 32'd2);
    check_val("both_lives", 32'(lives), 32'd2);
    check_val("both_ts", 32'(timer_start), 32'd1);

    // Asynchronous reset in RESTART while timer_start is high.
    #1;
    RESET_N = 1'b0;
    #1;
    check_val("arst_state", 32'(ctrl_state), 32'd0);
    check_val("arst_ts", 32'(timer_start), 32'd0);
    check_val("arst_round", 32'(round_num), 32'd1);
    check_val("arst_lives", 32'(lives), 32'd2);
    btn_start = 1'b1;
    cyc();
    RESET_N = 1'b1;
    cyc();
    check_val("held_rise_state", 32'(ctrl_state), 32'd1);
    check_val("held_rise_ts", 32'(timer_start), 32'd1);
    cyc();
    check_val("held_no_second", 32'(timer_start), 32'd0);
    btn_start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
